// File: rtl/risc_pkg.sv
// Shared definitions for the 4-bit RISC core front end and opcode decoder.
// Opcodes, instruction field positions and the fetch state encoding.
package risc_pkg;

  localparam int INSTR_W = 9;

  localparam int OPC_HI = 8;
  localparam int OPC_LO = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 4;
  localparam int RS1_HI = 3;
  localparam int RS1_LO = 2;
  localparam int RS2_HI = 1;
  localparam int RS2_LO = 0;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_ISSUE,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_issue.sv
// Instruction fetch and issue front end: fetches from imem into IR and
// hands opcode/register fields to the decoder over a valid/ready handshake.
module instr_fetch_issue
  import risc_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [2:0]         opcode,
  output logic [1:0]         rd,
  output logic [1:0]         rs1,
  output logic [1:0]         rs2,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  fetch_state_e       state_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic [CNT_W-1:0]   retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_valid) begin
            ir_q <= imem_rdata;
            // HALT leaves pc on the HALT word itself
            if (imem_rdata[OPC_HI:OPC_LO] == OP_HALT) begin
              state_q <= ST_HALTED;
            end else begin
              pc_q    <= pc_q + 1'b1;
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (issue_ready) begin
            if (retired_q != '1) retired_q <= retired_q + 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_HALTED: begin
          if (start) begin
            pc_q    <= RESET_PC;
            state_q <= ST_FETCH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign issue_valid = (state_q == ST_ISSUE);
  assign halted      = (state_q == ST_HALTED);
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALTED);

  assign opcode  = ir_q[OPC_HI:OPC_LO];
  assign rd      = ir_q[RD_HI:RD_LO];
  assign rs1     = ir_q[RS1_HI:RS1_LO];
  assign rs2     = ir_q[RS2_HI:RS2_LO];
  assign pc      = pc_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Directed bench for instr_fetch_issue with a latency-programmable imem model.
// Uses a 2-bit PC and 2-bit retire counter so wrap and saturation are reachable.
module tb_instr_fetch_issue;

  localparam int PC_W  = 2;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_valid;
  logic [8:0]       imem_rdata;
  logic             issue_valid;
  logic             issue_ready = 1'b0;
  logic [2:0]       opcode;
  logic [1:0]       rd, rs1, rs2;
  logic [PC_W-1:0]  pc;
  logic             busy, halted;
  logic [CNT_W-1:0] retired;

  int n_chk = 0;
  int n_fail = 0;

  // imem model
  logic [8:0]      mem [4];
  int              lat = 1;
  int              cnt = 0;
  int              req_cnt = 0;
  logic [PC_W-1:0] addr_q = '0;
  logic            mem_valid = 1'b0;
  logic [8:0]      mem_rdata = '0;
  logic            force_valid = 1'b0;
  logic [8:0]      force_data = '0;

  assign imem_valid = mem_valid | force_valid;
  assign imem_rdata = force_valid ? force_data : mem_rdata;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_valid <= 1'b0;
    if (imem_req) begin
      req_cnt <= req_cnt + 1;
      if (lat == 1) begin
        mem_valid <= 1'b1;
        mem_rdata <= mem[imem_addr];
      end else begin
        cnt    <= lat - 1;
        addr_q <= imem_addr;
      end
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        mem_valid <= 1'b1;
        mem_rdata <= mem[addr_q];
      end
    end
  end

  instr_fetch_issue #(
    .PC_W(PC_W), .RESET_PC('0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .pc(pc), .busy(busy), .halted(halted), .retired(retired)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({imem_req, issue_valid, busy, halted} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000",
               {imem_req, issue_valid, busy, halted});
    end
    n_chk++;
    if ({opcode, rd, rs1, rs2, pc, retired} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h want 0",
               {opcode, rd, rs1, rs2, pc, retired});
    end
  endtask

  task automatic test_basic();
    mem[0] = 9'b000_01_10_11;
    mem[1] = 9'b111_00_00_00;
    lat = 1;
    issue_ready = 1'b1;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++;
    if ({imem_req, imem_addr, busy} !== {1'b1, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL basic_req0: got req=%b addr=%0d busy=%b want 1 0 1",
               imem_req, imem_addr, busy);
    end
    tick(2);
    n_chk++;
    if ({issue_valid, opcode, rd, rs1, rs2} !== {1'b1, 9'b000_01_10_11}) begin
      n_fail++;
      $display("FAIL basic_issue: got v=%b op=%0d rd=%0d rs1=%0d rs2=%0d want 1 0 1 2 3",
               issue_valid, opcode, rd, rs1, rs2);
    end
    tick();
    n_chk++;
    if ({imem_req, imem_addr, retired} !== {1'b1, 2'd1, 2'd1}) begin
      n_fail++;
      $display("FAIL basic_req1: got req=%b addr=%0d ret=%0d want 1 1 1",
               imem_req, imem_addr, retired);
    end
    tick(2);
    n_chk++;
    if ({halted, busy, issue_valid, retired, pc} !== {3'b100, 2'd1, 2'd1}) begin
      n_fail++;
      $display("FAIL basic_halt: got h=%b b=%b v=%b ret=%0d pc=%0d want 1 0 0 1 1",
               halted, busy, issue_valid, retired, pc);
    end
  endtask

  task automatic test_stall();
    int reqs;
    mem[0] = 9'b000_11_00_01;
    mem[1] = 9'b011_10_01_00;
    mem[2] = 9'b111_00_00_00;
    lat = 1;
    issue_ready = 1'b0;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    reqs = req_cnt;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if ({issue_valid, opcode, rd, rs1, rs2, imem_req, retired}
          !== {1'b1, 9'b000_11_00_01, 1'b0, 2'd0}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b ir=%b req=%b ret=%0d want 1 000110001 0 0",
                 i, issue_valid, {opcode, rd, rs1, rs2}, imem_req, retired);
      end
      start = (i == 2);
      tick();
      start = 1'b0;
    end
    n_chk++;
    if (req_cnt !== reqs) begin
      n_fail++;
      $display("FAIL stall_noreq: got %0d requests want %0d", req_cnt, reqs);
    end
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    n_chk++;
    if ({retired, imem_req, imem_addr} !== {2'd1, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL stall_retire: got ret=%0d req=%b addr=%0d want 1 1 1",
               retired, imem_req, imem_addr);
    end
    tick(2);
    issue_ready = 1'b1;
    tick(3);
    n_chk++;
    if ({halted, retired, pc} !== {1'b1, 2'd2, 2'd2}) begin
      n_fail++;
      $display("FAIL stall_end: got h=%b ret=%0d pc=%0d want 1 2 2",
               halted, retired, pc);
    end
  endtask

  task automatic test_latency();
    mem[0] = 9'b001_01_01_10;
    mem[1] = 9'b111_00_00_00;
    lat = 4;
    issue_ready = 1'b0;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({issue_valid, imem_req, busy} !== 3'b001) begin
        n_fail++;
        $display("FAIL lat_wait[%0d]: got v=%b req=%b busy=%b want 0 0 1",
                 i, issue_valid, imem_req, busy);
      end
      tick();
    end
    n_chk++;
    if ({issue_valid, opcode, rd, rs1, rs2} !== {1'b1, 9'b001_01_01_10}) begin
      n_fail++;
      $display("FAIL lat_issue: got v=%b ir=%b want 1 001010110",
               issue_valid, {opcode, rd, rs1, rs2});
    end
    force_data = 9'b010_11_11_11;
    force_valid = 1'b1;
    tick();
    force_valid = 1'b0;
    n_chk++;
    if ({issue_valid, opcode, rd, rs1, rs2, pc} !== {1'b1, 9'b001_01_01_10, 2'd1}) begin
      n_fail++;
      $display("FAIL lat_stray: got v=%b ir=%b pc=%0d want 1 001010110 1",
               issue_valid, {opcode, rd, rs1, rs2}, pc);
    end
    issue_ready = 1'b1;
    tick(6);
    n_chk++;
    if ({halted, retired} !== {1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL lat_halt: got h=%b ret=%0d want 1 1", halted, retired);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_pc;
    logic [1:0] exp_ret;
    mem[0] = 9'b000_00_01_10;
    mem[1] = 9'b000_01_10_11;
    mem[2] = 9'b000_10_11_00;
    mem[3] = 9'b000_11_00_01;
    lat = 1;
    issue_ready = 1'b1;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if ({imem_req, imem_addr} !== {1'b1, 2'(k)}) begin
        n_fail++;
        $display("FAIL wrap_addr[%0d]: got req=%b addr=%0d want 1 %0d",
                 k, imem_req, imem_addr, k);
      end
      tick(2);
      exp_pc = 2'(k + 1);
      n_chk++;
      if ({issue_valid, opcode, rd, rs1, rs2, pc} !== {1'b1, mem[k], exp_pc}) begin
        n_fail++;
        $display("FAIL wrap_issue[%0d]: got v=%b ir=%b pc=%0d want 1 %b %0d",
                 k, issue_valid, {opcode, rd, rs1, rs2}, pc, mem[k], exp_pc);
      end
      tick();
      exp_ret = (k >= 2) ? 2'd3 : 2'(k + 1);
      n_chk++;
      if (retired !== exp_ret) begin
        n_fail++;
        $display("FAIL wrap_retired[%0d]: got %0d want %0d", k, retired, exp_ret);
      end
    end
    n_chk++;
    if ({imem_req, imem_addr, pc} !== {1'b1, 2'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL wrap_again: got req=%b addr=%0d pc=%0d want 1 0 0",
               imem_req, imem_addr, pc);
    end
  endtask

  task automatic test_reset_mid();
    mem[0] = 9'b011_11_11_11;
    lat = 2;
    issue_ready = 1'b1;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++;
    if ({busy, issue_valid, halted, imem_req} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_flags: got b=%b v=%b h=%b req=%b want 0 0 0 0",
               busy, issue_valid, halted, imem_req);
    end
    tick();
    n_chk++;
    if ({busy, issue_valid, opcode, rd, rs1, rs2, pc} !== 13'd0) begin
      n_fail++;
      $display("FAIL rstmid_late: got b=%b v=%b ir=%b pc=%0d want 0 0 0 0",
               busy, issue_valid, {opcode, rd, rs1, rs2}, pc);
    end
    tick(2);
    lat = 1;
  endtask

  task automatic test_restart();
    mem[0] = 9'b000_01_10_11;
    mem[1] = 9'b111_00_00_00;
    lat = 1;
    issue_ready = 1'b1;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(5);
    mem[0] = 9'b010_01_10_11;
    n_chk++;
    if ({halted, retired, pc} !== {1'b1, 2'd1, 2'd1}) begin
      n_fail++;
      $display("FAIL restart_pre: got h=%b ret=%0d pc=%0d want 1 1 1",
               halted, retired, pc);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++;
    if ({halted, imem_req, imem_addr, retired} !== {2'b01, 2'd0, 2'd1}) begin
      n_fail++;
      $display("FAIL restart_fetch: got h=%b req=%b addr=%0d ret=%0d want 0 1 0 1",
               halted, imem_req, imem_addr, retired);
    end
    tick(2);
    n_chk++;
    if ({issue_valid, opcode} !== {1'b1, 3'b010}) begin
      n_fail++;
      $display("FAIL restart_issue: got v=%b op=%0d want 1 2", issue_valid, opcode);
    end
    tick();
    n_chk++;
    if (retired !== 2'd2) begin
      n_fail++;
      $display("FAIL restart_retired: got %0d want 2", retired);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_stall();
    test_latency();
    test_wrap();
    test_reset_mid();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
